// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory bus master
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_t;

    localparam logic MEM_READ    = 1'b0;
    localparam logic MEM_WRITE   = 1'b1;
    localparam logic MEM_DATA    = 1'b0;
    localparam logic MEM_ADDRESS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_ADDR = 3'd4,
        ST_RESP    = 3'd5
    } master_state_t;

    // SIZE_DOUBLE has no 64-bit path on this bus, so it is checked like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (mem_size_t'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - saturating phase timeout counter
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_FULL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // Flags the cycle whose closing edge brings the count to TIMEOUT_CYCLES.
    assign expired = enable && (count_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU load/store to tri-state memory bus sequencer
module mem_bus_master
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read_write,
    output logic        mem_data_address,
    output logic        mem_input_enable,
    output logic        mem_output_enable,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic        mem_done_or_valid,
    output logic [31:0] bus_out,
    output logic        bus_oe,
    input  logic [31:0] bus_in
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    master_state_t state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          mem_read_write_q, mem_read_write_d;
    logic          mem_data_address_q, mem_data_address_d;
    logic          mem_input_enable_q, mem_input_enable_d;
    logic          mem_output_enable_q, mem_output_enable_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic          mem_sign_q, mem_sign_d;
    logic [31:0]   bus_out_q, bus_out_d;
    logic          bus_oe_q, bus_oe_d;

    logic             in_addr_phase;
    logic [CNT_W-1:0] tmo_count;
    logic             tmo_expired;
    logic             done_ok;

    assign in_addr_phase = (state_q == ST_RD_ADDR) || (state_q == ST_WR_ADDR);

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!in_addr_phase),
        .enable  (in_addr_phase),
        .count   (tmo_count),
        .expired (tmo_expired)
    );

    // A zero count marks the entry cycle, where done may still be high from the previous access.
    assign done_ok = mem_done_or_valid && (tmo_count != '0);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_size_d   = mem_size_q;
        mem_sign_d   = mem_sign_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    mem_size_d = req_size;
                    mem_sign_d = req_sign;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else if (req_we) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (done_ok) begin
                    state_d = ST_RD_DATA;
                end else if (tmo_expired) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                end
            end
            ST_RD_DATA: begin
                resp_rdata_d = bus_in;
                state_d      = ST_RESP;
            end
            ST_WR_DATA: begin
                state_d = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                if (done_ok) begin
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus-facing outputs are decoded from the next state so they register alongside it.
        req_ready_d         = (state_d == ST_IDLE);
        resp_valid_d        = (state_d == ST_RESP);
        mem_read_write_d    = ((state_d == ST_WR_DATA) || (state_d == ST_WR_ADDR)) ? MEM_WRITE : MEM_READ;
        mem_data_address_d  = ((state_d == ST_RD_ADDR) || (state_d == ST_WR_ADDR)) ? MEM_ADDRESS : MEM_DATA;
        mem_input_enable_d  = (state_d == ST_RD_ADDR) || (state_d == ST_WR_DATA) || (state_d == ST_WR_ADDR);
        mem_output_enable_d = (state_d == ST_RD_DATA);
        bus_oe_d            = mem_input_enable_d;

        bus_out_d = bus_out_q;
        if (state_d == ST_WR_DATA) begin
            bus_out_d = wdata_d;
        end else if ((state_d == ST_RD_ADDR) || (state_d == ST_WR_ADDR)) begin
            bus_out_d = addr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q             <= ST_IDLE;
            addr_q              <= '0;
            wdata_q             <= '0;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_rdata_q        <= '0;
            resp_err_q          <= 1'b0;
            mem_read_write_q    <= 1'b0;
            mem_data_address_q  <= 1'b0;
            mem_input_enable_q  <= 1'b0;
            mem_output_enable_q <= 1'b0;
            mem_size_q          <= SIZE_WORD;
            mem_sign_q          <= 1'b0;
            bus_out_q           <= '0;
            bus_oe_q            <= 1'b0;
        end else begin
            state_q             <= state_d;
            addr_q              <= addr_d;
            wdata_q             <= wdata_d;
            req_ready_q         <= req_ready_d;
            resp_valid_q        <= resp_valid_d;
            resp_rdata_q        <= resp_rdata_d;
            resp_err_q          <= resp_err_d;
            mem_read_write_q    <= mem_read_write_d;
            mem_data_address_q  <= mem_data_address_d;
            mem_input_enable_q  <= mem_input_enable_d;
            mem_output_enable_q <= mem_output_enable_d;
            mem_size_q          <= mem_size_d;
            mem_sign_q          <= mem_sign_d;
            bus_out_q           <= bus_out_d;
            bus_oe_q            <= bus_oe_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = resp_rdata_q;
    assign resp_err          = resp_err_q;
    assign mem_read_write    = mem_read_write_q;
    assign mem_data_address  = mem_data_address_q;
    assign mem_input_enable  = mem_input_enable_q;
    assign mem_output_enable = mem_output_enable_q;
    assign mem_size          = mem_size_q;
    assign mem_sign          = mem_sign_q;
    assign bus_out           = bus_out_q;
    assign bus_oe            = bus_oe_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - randomized self-checking bench for mem_bus_master
module tb_mem_bus_master;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'd2;
    logic        req_sign = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read_write;
    logic        mem_data_address;
    logic        mem_input_enable;
    logic        mem_output_enable;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        mem_done_or_valid = 1'b0;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic [31:0] bus_in;

    // Memory-side state driven by the responder process
    logic [31:0] done_pat = '0;
    logic        stale_level = 1'b0;
    logic [31:0] float_val = 32'h1234_5678;
    logic [31:0] rd_drive = '0;
    logic [31:0] wbuf = '0;
    int          addr_cyc = 0;
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] exp_rdata = '0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clock = ~clock;

    assign bus_in = bus_oe ? bus_out : (mem_output_enable ? rd_drive : float_val);

    mem_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_size          (req_size),
        .req_sign          (req_sign),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .mem_read_write    (mem_read_write),
        .mem_data_address  (mem_data_address),
        .mem_input_enable  (mem_input_enable),
        .mem_output_enable (mem_output_enable),
        .mem_size          (mem_size),
        .mem_sign          (mem_sign),
        .mem_done_or_valid (mem_done_or_valid),
        .bus_out           (bus_out),
        .bus_oe            (bus_oe),
        .bus_in            (bus_in)
    );

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: done per address-phase cycle comes from done_pat (bit 1 = entry cycle)
    initial begin
        forever begin
            @(negedge clock);
            if (mem_input_enable && mem_data_address) begin
                addr_cyc++;
                mem_done_or_valid = (addr_cyc < 32) ? done_pat[addr_cyc] : 1'b0;
                if (!mem_read_write) begin
                    rd_drive = mem_rd(bus_out);
                end else if (addr_cyc >= 2 && mem_done_or_valid) begin
                    mem[bus_out] = wbuf;
                end
            end else begin
                addr_cyc = 0;
                mem_done_or_valid = stale_level;
                if (mem_input_enable && mem_read_write) wbuf = bus_in;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sign, input logic [31:0] pat,
                          input logic stale);
        logic mis;
        logic terr;
        int   k;
        int   lat;
        int   cyc;
        logic seen;
        mis = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
        k = 0;
        for (int j = 2; j <= TMO; j++) if (k == 0 && pat[j]) k = j;
        if (mis) begin
            terr = 1'b1; lat = 1;
        end else if (k == 0) begin
            terr = 1'b1; lat = we ? TMO + 2 : TMO + 1;
        end else begin
            terr = 1'b0; lat = k + 2;
        end

        @(negedge clock);
        done_pat    = pat;
        stale_level = stale;
        float_val   = $urandom;
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wdata;
        req_size    = size;
        req_sign    = sign;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc <= 40) begin
            chk("excl_drive", 32'(bus_oe & mem_output_enable), 32'd0);
            if (mis) chk("misalign_no_ie", 32'(mem_input_enable), 32'd0);
            if (mem_input_enable && mem_data_address) chk("addr_phase_bus", bus_out, addr);
            if (mem_input_enable && !mem_data_address) chk("wr_data_bus", bus_out, wdata);
            if (mem_input_enable) chk("rw_dir", 32'(mem_read_write), 32'(we));
            if (resp_valid) begin
                seen = 1'b1;
                if (!we && !terr) exp_rdata = ref_rd(addr);
                chk("latency", 32'(cyc), 32'(lat));
                chk("resp_err", 32'(resp_err), 32'(terr));
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("mem_size", 32'(mem_size), 32'(size));
                chk("mem_sign", 32'(mem_sign), 32'(sign));
            end else begin
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                @(posedge clock); #1;
                cyc++;
            end
        end
        if (!seen) chk("resp_seen", 32'd0, 32'd1);
        if (we && !terr) ref_mem[addr] = wdata;

        @(posedge clock); #1;
        chk("resp_one_shot", 32'(resp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_ie", 32'(mem_input_enable), 32'd0);
        chk("idle_bus_oe", 32'(bus_oe), 32'd0);
    endtask

    task automatic reset_mid_write();
        @(negedge clock);
        done_pat    = 32'h0000_0020;
        stale_level = 1'b0;
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_addr    = 32'h0000_0040;
        req_wdata   = 32'hFEED_F00D;
        req_size    = 2'd2;
        req_sign    = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("in_wr_addr", {29'd0, mem_data_address, mem_input_enable, mem_read_write}, 32'd7);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        exp_rdata = '0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ie", 32'(mem_input_enable), 32'd0);
        chk("rst_bus_oe", 32'(bus_oe), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, exp_rdata);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_bus_out", bus_out, 32'd0);
        chk("rst_bus_ctl", {27'd0, bus_oe, mem_input_enable, mem_output_enable,
                            mem_read_write, mem_data_address}, 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd2);
        chk("rst_mem_sign", 32'(mem_sign), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        mem[32'h08]     = 32'h0020_8133;
        ref_mem[32'h08] = 32'h0020_8133;
        do_req(1'b0, 32'h0000_0008, 32'h0, 2'd2, 1'b0, 32'h0000_0004, 1'b0);
        do_req(1'b1, 32'h0000_0190, 32'h0000_00AB, 2'd0, 1'b0, 32'h0000_0004, 1'b0);
        do_req(1'b0, 32'h0000_0190, 32'h0, 2'd0, 1'b1, 32'h0000_0004, 1'b0);
        do_req(1'b0, 32'h0000_0003, 32'h0, 2'd1, 1'b1, 32'h0000_0004, 1'b0);
        do_req(1'b0, 32'h0000_0002, 32'h0, 2'd3, 1'b0, 32'h0000_0004, 1'b0);
        do_req(1'b0, 32'h0000_0008, 32'h0, 2'd2, 1'b0, 32'h0000_0000, 1'b0);
        do_req(1'b1, 32'h0000_0010, 32'h5555_AAAA, 2'd2, 1'b0, 32'h0000_0000, 1'b0);
        do_req(1'b0, 32'h0000_0008, 32'h0, 2'd2, 1'b0, 32'h0000_000A, 1'b1);
        do_req(1'b0, 32'h0000_0008, 32'h0, 2'd2, 1'b0, 32'h0000_0006, 1'b1);
        do_req(1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 2'd2, 1'b0, 32'h0000_0102, 1'b1);
        do_req(1'b0, 32'h0000_0020, 32'h0, 2'd2, 1'b0, 32'h0000_0100, 1'b0);

        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(0, 3));
            do_req(we, addr, $urandom, size, 1'($urandom_range(0, 1)),
                   $urandom & $urandom, 1'($urandom_range(0, 1)));
        end

        reset_mid_write();
        do_req(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0, 32'h0000_0004, 1'b0);
        do_req(1'b0, 32'h0000_0190, 32'h0, 2'd0, 1'b0, 32'h0000_0008, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
